// File: rtl/pmem_arb_pkg.sv
// Shared types and constants for the pmem outport arbiter and its tracking FIFO.
package pmem_arb_pkg;

  localparam int unsigned LEN_W   = 8;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned STRB_W  = 4;
  localparam int unsigned EXP_W   = LEN_W + 1;
  localparam int unsigned ENTRY_W = 1 + EXP_W;

  localparam logic ARB_M0 = 1'b0;
  localparam logic ARB_M1 = 1'b1;

  typedef enum logic [0:0] {StIdle, StWrBurst} lock_state_e;

  typedef struct packed {
    logic             id;
    logic [EXP_W-1:0] exp;
  } track_entry_t;

  // Reads return len+1 beats; a write burst returns a single response.
  function automatic logic [EXP_W-1:0] exp_acks(input logic rd, input logic [LEN_W-1:0] len);
    return rd ? ({1'b0, len} + EXP_W'(1)) : EXP_W'(1);
  endfunction

endpackage

// File: rtl/pmem_arb_fifo.sv
// Small synchronous FIFO with push/pop handshakes; full/empty from a registered count.
module pmem_arb_fifo #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_in_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic             accept_o,
  output logic [WIDTH-1:0] data_out_o
);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              do_push, do_pop;

  assign accept_o   = (count_q != (ADDR_W+1)'(DEPTH));
  assign valid_o    = (count_q != '0);
  assign data_out_o = mem_q[rd_ptr_q];
  assign do_push    = push_i & accept_o;
  assign do_pop     = pop_i & valid_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == ADDR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = (rd_ptr_q == ADDR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_in_i;
  end

endmodule

// File: rtl/pmem_outport_arb.sv
// 2:1 round-robin arbiter for the pmem outport with write-burst locking and in-order
// response routing through a tracking FIFO of {master, expected acks}.
module pmem_outport_arb
  import pmem_arb_pkg::*;
#(
  parameter int unsigned OUTSTANDING = 4,
  parameter int unsigned ADDR_W      = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_rd_i,
  input  logic [STRB_W-1:0] m0_wr_i,
  input  logic [LEN_W-1:0]  m0_len_i,
  input  logic [31:0]       m0_addr_i,
  input  logic [DATA_W-1:0] m0_write_data_i,
  input  logic              m1_rd_i,
  input  logic [STRB_W-1:0] m1_wr_i,
  input  logic [LEN_W-1:0]  m1_len_i,
  input  logic [31:0]       m1_addr_i,
  input  logic [DATA_W-1:0] m1_write_data_i,
  output logic              m0_accept_o,
  output logic              m0_ack_o,
  output logic              m0_error_o,
  output logic [DATA_W-1:0] m0_read_data_o,
  output logic              m1_accept_o,
  output logic              m1_ack_o,
  output logic              m1_error_o,
  output logic [DATA_W-1:0] m1_read_data_o,
  output logic              outport_rd_o,
  output logic [STRB_W-1:0] outport_wr_o,
  output logic [LEN_W-1:0]  outport_len_o,
  output logic [31:0]       outport_addr_o,
  output logic [DATA_W-1:0] outport_write_data_o,
  input  logic              outport_accept_i,
  input  logic              outport_ack_i,
  input  logic              outport_error_i,
  input  logic [DATA_W-1:0] outport_read_data_i
);

  lock_state_e      state_q;
  logic             lock_id_q, last_grant_q;
  logic [LEN_W-1:0] beat_cnt_q, resp_cnt_q;

  logic         req0, req1, gnt_valid, gnt_id, beat_fire, first_beat;
  logic         fifo_valid, fifo_accept, ack_hit, pop;
  track_entry_t push_entry, head;

  assign req0 = m0_rd_i | (|m0_wr_i);
  assign req1 = m1_rd_i | (|m1_wr_i);

  // A locked burst bypasses the full check: its entry was pushed on the first beat.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = ARB_M0;
    if (state_q == StWrBurst) begin
      gnt_id    = lock_id_q;
      gnt_valid = lock_id_q ? req1 : req0;
    end else if (fifo_accept) begin
      if (req0 && req1) begin
        gnt_valid = 1'b1;
        gnt_id    = ~last_grant_q;
      end else if (req0) begin
        gnt_valid = 1'b1;
        gnt_id    = ARB_M0;
      end else if (req1) begin
        gnt_valid = 1'b1;
        gnt_id    = ARB_M1;
      end
    end
  end

  always_comb begin
    outport_rd_o         = 1'b0;
    outport_wr_o         = '0;
    outport_len_o        = '0;
    outport_addr_o       = '0;
    outport_write_data_o = '0;
    if (gnt_valid) begin
      if (gnt_id == ARB_M1) begin
        outport_rd_o         = m1_rd_i;
        outport_wr_o         = m1_wr_i;
        outport_len_o        = m1_len_i;
        outport_addr_o       = m1_addr_i;
        outport_write_data_o = m1_write_data_i;
      end else begin
        outport_rd_o         = m0_rd_i;
        outport_wr_o         = m0_wr_i;
        outport_len_o        = m0_len_i;
        outport_addr_o       = m0_addr_i;
        outport_write_data_o = m0_write_data_i;
      end
    end
  end

  assign m0_accept_o = gnt_valid & (gnt_id == ARB_M0) & outport_accept_i;
  assign m1_accept_o = gnt_valid & (gnt_id == ARB_M1) & outport_accept_i;
  assign beat_fire   = gnt_valid & outport_accept_i;
  assign first_beat  = beat_fire & (state_q == StIdle);

  assign push_entry.id  = gnt_id;
  assign push_entry.exp = exp_acks(outport_rd_o, outport_len_o);

  pmem_arb_fifo #(
    .WIDTH  (ENTRY_W),
    .DEPTH  (OUTSTANDING),
    .ADDR_W (ADDR_W)
  ) u_track_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (first_beat),
    .data_in_i  (push_entry),
    .pop_i      (pop),
    .valid_o    (fifo_valid),
    .accept_o   (fifo_accept),
    .data_out_o (head)
  );

  // Acks with nothing outstanding are dropped.
  assign ack_hit        = outport_ack_i & fifo_valid;
  assign pop            = ack_hit & ({1'b0, resp_cnt_q} == (head.exp - EXP_W'(1)));
  assign m0_ack_o       = ack_hit & (head.id == ARB_M0);
  assign m1_ack_o       = ack_hit & (head.id == ARB_M1);
  assign m0_error_o     = m0_ack_o & outport_error_i;
  assign m1_error_o     = m1_ack_o & outport_error_i;
  assign m0_read_data_o = m0_ack_o ? outport_read_data_i : '0;
  assign m1_read_data_o = m1_ack_o ? outport_read_data_i : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      lock_id_q    <= ARB_M0;
      last_grant_q <= ARB_M1;
      beat_cnt_q   <= '0;
      resp_cnt_q   <= '0;
    end else begin
      if (pop)          resp_cnt_q <= '0;
      else if (ack_hit) resp_cnt_q <= resp_cnt_q + 1'b1;
      unique case (state_q)
        StIdle: begin
          if (first_beat) begin
            last_grant_q <= gnt_id;
            if ((|outport_wr_o) && (outport_len_o != '0)) begin
              state_q    <= StWrBurst;
              lock_id_q  <= gnt_id;
              beat_cnt_q <= outport_len_o;
            end
          end
        end
        StWrBurst: begin
          if (beat_fire) begin
            beat_cnt_q <= beat_cnt_q - 1'b1;
            if (beat_cnt_q == LEN_W'(1)) state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pmem_outport_arb.sv
// Directed scenarios plus randomized traffic checked against a queue-based model.
module tb_pmem_outport_arb;

  localparam int OUTSTANDING = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd [2];
  logic [3:0]  wr [2];
  logic [7:0]  len [2];
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic        dn_accept, dn_ack, dn_err;
  logic [31:0] dn_rdata;

  logic        m0_acc, m1_acc, m0_ack, m1_ack, m0_err, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        o_rd;
  logic [3:0]  o_wr;
  logic [7:0]  o_len;
  logic [31:0] o_addr, o_wdata;
  logic [1:0]  accv, ackv, errv;

  int total = 0;
  int bad = 0;

  assign accv = {m1_acc, m0_acc};
  assign ackv = {m1_ack, m0_ack};
  assign errv = {m1_err, m0_err};

  always #5 clk = ~clk;

  pmem_outport_arb #(
    .OUTSTANDING (OUTSTANDING),
    .ADDR_W      (2)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .m0_rd_i              (rd[0]),
    .m0_wr_i              (wr[0]),
    .m0_len_i             (len[0]),
    .m0_addr_i            (addr[0]),
    .m0_write_data_i      (wdata[0]),
    .m1_rd_i              (rd[1]),
    .m1_wr_i              (wr[1]),
    .m1_len_i             (len[1]),
    .m1_addr_i            (addr[1]),
    .m1_write_data_i      (wdata[1]),
    .m0_accept_o          (m0_acc),
    .m0_ack_o             (m0_ack),
    .m0_error_o           (m0_err),
    .m0_read_data_o       (m0_rdata),
    .m1_accept_o          (m1_acc),
    .m1_ack_o             (m1_ack),
    .m1_error_o           (m1_err),
    .m1_read_data_o       (m1_rdata),
    .outport_rd_o         (o_rd),
    .outport_wr_o         (o_wr),
    .outport_len_o        (o_len),
    .outport_addr_o       (o_addr),
    .outport_write_data_o (o_wdata),
    .outport_accept_i     (dn_accept),
    .outport_ack_i        (dn_ack),
    .outport_error_i      (dn_err),
    .outport_read_data_i  (dn_rdata)
  );

  task automatic idle();
    for (int n = 0; n < 2; n++) begin
      rd[n] = 1'b0; wr[n] = '0; len[n] = '0; addr[n] = '0; wdata[n] = '0;
    end
    dn_accept = 1'b1; dn_ack = 1'b0; dn_err = 1'b0; dn_rdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk); idle(); rst = 1'b1;
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk); idle(); #1;
    total++;
    if ({o_rd, o_wr, o_len, o_addr, o_wdata, accv, ackv, errv} !== '0) begin
      bad++; $display("FAIL reset_outputs got rd=%b wr=%h acc=%b ack=%b exp all zero",
                      o_rd, o_wr, accv, ackv);
    end
    @(negedge clk); dn_ack = 1'b1; dn_err = 1'b1; dn_rdata = 32'hFFFF_FFFF; #1;
    total++;
    if ({ackv, errv, m0_rdata, m1_rdata} !== '0) begin
      bad++; $display("FAIL reset_stray_ack got ack=%b err=%b exp 00/00", ackv, errv);
    end
  endtask

  task automatic test_round_robin();
    @(negedge clk); idle();
    rd[0] = 1'b1; rd[1] = 1'b1; addr[0] = 32'h10; addr[1] = 32'h20; #1;
    total++;
    if ({accv, o_rd, o_addr} !== {2'b01, 1'b1, 32'h10}) begin
      bad++; $display("FAIL rr_first got acc=%b addr=%h exp acc=01 addr=10", accv, o_addr);
    end
    @(negedge clk); rd[0] = 1'b0; #1;
    total++;
    if ({accv, o_addr} !== {2'b10, 32'h20}) begin
      bad++; $display("FAIL rr_second got acc=%b addr=%h exp acc=10 addr=20", accv, o_addr);
    end
    @(negedge clk); rd[1] = 1'b0; dn_ack = 1'b1; dn_rdata = 32'hA5A5_0000; #1;
    total++;
    if ({ackv, m0_rdata, m1_rdata} !== {2'b01, 32'hA5A5_0000, 32'h0}) begin
      bad++; $display("FAIL rr_ack_m0 got ack=%b d0=%h exp ack=01 d0=a5a50000", ackv, m0_rdata);
    end
    @(negedge clk); dn_ack = 1'b0; #1;
    @(negedge clk); dn_ack = 1'b1; dn_rdata = 32'h5A5A_0001; #1;
    total++;
    if ({ackv, m1_rdata, m0_rdata} !== {2'b10, 32'h5A5A_0001, 32'h0}) begin
      bad++; $display("FAIL rr_ack_m1 got ack=%b d1=%h exp ack=10 d1=5a5a0001", ackv, m1_rdata);
    end
    @(negedge clk); idle();
  endtask

  task automatic test_wr_burst();
    @(negedge clk); idle();
    wr[1] = 4'hF; len[1] = 8'd3; addr[1] = 32'h1000; wdata[1] = 32'hD0; #1;
    total++;
    if ({accv, o_wr, o_len, o_addr} !== {2'b10, 4'hF, 8'd3, 32'h1000}) begin
      bad++; $display("FAIL wb_first got acc=%b wr=%h len=%0d addr=%h exp 10/f/3/1000",
                      accv, o_wr, o_len, o_addr);
    end
    for (int i = 1; i < 4; i++) begin
      @(negedge clk); rd[0] = 1'b1; addr[0] = 32'h40; wdata[1] = 32'hD0 + i; #1;
      total++;
      if ({accv, o_rd, o_wdata} !== {2'b10, 1'b0, 32'hD0 + i}) begin
        bad++; $display("FAIL wb_beat%0d got acc=%b rd=%b wd=%h exp acc=10 rd=0 wd=%h",
                        i, accv, o_rd, o_wdata, 32'hD0 + i);
      end
    end
    @(negedge clk); wr[1] = '0; #1;
    total++;
    if ({accv, o_rd, o_addr} !== {2'b01, 1'b1, 32'h40}) begin
      bad++; $display("FAIL wb_m0_after got acc=%b rd=%b addr=%h exp 01/1/40", accv, o_rd, o_addr);
    end
    @(negedge clk); rd[0] = 1'b0; dn_ack = 1'b1; #1;
    total++;
    if (ackv !== 2'b10) begin bad++; $display("FAIL wb_ack_m1 got=%b exp=10", ackv); end
    @(negedge clk); #1;
    total++;
    if (ackv !== 2'b01) begin bad++; $display("FAIL wb_ack_m0 got=%b exp=01", ackv); end
    @(negedge clk); idle();
  endtask

  task automatic test_read_burst();
    int c0 = 0;
    int c1 = 0;
    @(negedge clk); idle(); rd[0] = 1'b1; len[0] = 8'd7; addr[0] = 32'h80; #1;
    total++;
    if ({accv, o_len} !== {2'b01, 8'd7}) begin
      bad++; $display("FAIL rb_accept got acc=%b len=%0d exp 01/7", accv, o_len);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); rd[0] = 1'b0; dn_ack = 1'b1; dn_rdata = i; #1;
      c0 += int'(m0_ack); c1 += int'(m1_ack);
    end
    total++;
    if (c0 != 8 || c1 != 0) begin
      bad++; $display("FAIL rb_ack_count got m0=%0d m1=%0d exp m0=8 m1=0", c0, c1);
    end
    @(negedge clk); #1;
    total++;
    if (ackv !== 2'b00) begin bad++; $display("FAIL rb_popped got=%b exp=00", ackv); end
    @(negedge clk); idle();
  endtask

  task automatic test_fifo_full();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); idle(); rd[0] = 1'b1; addr[0] = i; #1;
      total++;
      if (accv !== 2'b01) begin bad++; $display("FAIL full_fill%0d got=%b exp=01", i, accv); end
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); addr[0] = 32'h99; #1;
      total++;
      if ({o_rd, accv} !== 3'b000) begin
        bad++; $display("FAIL full_block%0d got rd=%b acc=%b exp 0/00", i, o_rd, accv);
      end
    end
    @(negedge clk); dn_ack = 1'b1; #1;
    total++;
    if ({ackv, o_rd, accv} !== {2'b01, 1'b0, 2'b00}) begin
      bad++; $display("FAIL full_ack_cycle got ack=%b rd=%b acc=%b exp 01/0/00", ackv, o_rd, accv);
    end
    @(negedge clk); dn_ack = 1'b0; #1;
    total++;
    if ({o_rd, accv, o_addr} !== {1'b1, 2'b01, 32'h99}) begin
      bad++; $display("FAIL full_regrant got rd=%b acc=%b addr=%h exp 1/01/99", o_rd, accv, o_addr);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); rd[0] = 1'b0; dn_ack = 1'b1; #1;
      total++;
      if (ackv !== 2'b01) begin bad++; $display("FAIL full_drain%0d got=%b exp=01", i, ackv); end
    end
    @(negedge clk); #1;
    total++;
    if (ackv !== 2'b00) begin bad++; $display("FAIL full_empty got=%b exp=00", ackv); end
    @(negedge clk); idle();
  endtask

  task automatic test_error();
    @(negedge clk); idle(); rd[1] = 1'b1; len[1] = 8'd1; #1;
    total++;
    if (accv !== 2'b10) begin bad++; $display("FAIL err_accept got=%b exp=10", accv); end
    @(negedge clk); rd[1] = 1'b0; dn_ack = 1'b1; dn_err = 1'b0; #1;
    total++;
    if ({ackv, errv} !== 4'b1000) begin
      bad++; $display("FAIL err_first got ack=%b err=%b exp 10/00", ackv, errv);
    end
    @(negedge clk); dn_err = 1'b1; #1;
    total++;
    if ({ackv, errv} !== 4'b1010) begin
      bad++; $display("FAIL err_second got ack=%b err=%b exp 10/10", ackv, errv);
    end
    @(negedge clk); #1;
    total++;
    if ({ackv, errv} !== 4'b0000) begin
      bad++; $display("FAIL err_popped got ack=%b err=%b exp 00/00", ackv, errv);
    end
    @(negedge clk); idle();
  endtask

  task automatic test_reset_mid();
    @(negedge clk); idle(); wr[1] = 4'hF; len[1] = 8'd3; addr[1] = 32'h2000; #1;
    total++;
    if (accv !== 2'b10) begin bad++; $display("FAIL rm_beat1 got=%b exp=10", accv); end
    @(negedge clk); #1;
    total++;
    if (accv !== 2'b10) begin bad++; $display("FAIL rm_beat2 got=%b exp=10", accv); end
    @(negedge clk); idle(); rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    total++;
    if ({o_rd, o_wr, o_len, o_addr, o_wdata, accv, ackv, errv} !== '0) begin
      bad++; $display("FAIL rm_outputs got wr=%h acc=%b ack=%b exp all zero", o_wr, accv, ackv);
    end
    @(negedge clk); dn_ack = 1'b1; #1;
    total++;
    if (ackv !== 2'b00) begin bad++; $display("FAIL rm_stray_ack got=%b exp=00", ackv); end
    @(negedge clk); dn_ack = 1'b0; rd[0] = 1'b1; rd[1] = 1'b1; #1;
    total++;
    if (accv !== 2'b01) begin bad++; $display("FAIL rm_unlocked got=%b exp=01", accv); end
    do_reset();
  endtask

  task automatic test_random();
    int          qid[$];
    int          qleft[$];
    int          lock_m = -1;
    int          lock_left = 0;
    int          last = 1;
    bit          busy [2];
    bit          isrd [2];
    int          blen [2];
    int          sent [2];
    logic [3:0]  strb [2];
    logic [31:0] baddr [2];
    bit          drained = 1'b0;
    bit          gen;
    bit          r [2];
    int          g;
    logic [1:0]  e_acc, e_ack;
    logic        e_rd;
    logic [3:0]  e_wr;
    logic [7:0]  e_len;
    logic [31:0] e_addr, e_wd;

    do_reset();
    for (int n = 0; n < 2; n++) begin busy[n] = 1'b0; sent[n] = 0; end
    for (int cyc = 0; cyc < 8000; cyc++) begin
      gen = (cyc < 1500);
      if (!gen && !busy[0] && !busy[1] && qid.size() == 0) begin
        drained = 1'b1;
        break;
      end
      @(negedge clk);
      for (int n = 0; n < 2; n++) begin
        if (!busy[n] && gen && $urandom_range(2) == 0) begin
          busy[n]  = 1'b1;
          isrd[n]  = $urandom_range(1) == 1;
          blen[n]  = ($urandom_range(15) == 0) ? $urandom_range(20, 4) : $urandom_range(3);
          sent[n]  = 0;
          strb[n]  = 4'($urandom_range(15, 1));
          baddr[n] = $urandom;
        end
        rd[n]    = busy[n] && isrd[n];
        wr[n]    = (busy[n] && !isrd[n]) ? strb[n] : 4'h0;
        len[n]   = busy[n] ? 8'(blen[n]) : 8'h0;
        addr[n]  = busy[n] ? baddr[n] : 32'h0;
        wdata[n] = $urandom;
        r[n]     = rd[n] || (wr[n] != 4'h0);
      end
      dn_accept = $urandom_range(3) != 0;
      dn_ack    = gen ? ($urandom_range(2) != 0) : 1'b1;
      dn_err    = $urandom_range(7) == 0;
      dn_rdata  = $urandom;
      #1;
      g = -1;
      if (lock_m >= 0) g = r[lock_m] ? lock_m : -1;
      else if (qid.size() < OUTSTANDING) begin
        if (r[0] && r[1]) g = 1 - last;
        else if (r[0]) g = 0;
        else if (r[1]) g = 1;
      end
      e_acc  = (g >= 0 && dn_accept) ? 2'(1 << g) : 2'b00;
      e_rd   = (g >= 0) ? rd[g] : 1'b0;
      e_wr   = (g >= 0) ? wr[g] : 4'h0;
      e_len  = (g >= 0) ? len[g] : 8'h0;
      e_addr = (g >= 0) ? addr[g] : 32'h0;
      e_wd   = (g >= 0) ? wdata[g] : 32'h0;
      e_ack  = (dn_ack && qid.size() > 0) ? 2'(1 << qid[0]) : 2'b00;
      total++;
      if ({accv, o_rd, o_wr} !== {e_acc, e_rd, e_wr}) begin
        bad++; $display("FAIL rnd_grant cyc=%0d got acc=%b rd=%b wr=%h exp acc=%b rd=%b wr=%h",
                        cyc, accv, o_rd, o_wr, e_acc, e_rd, e_wr);
      end
      total++;
      if ({o_len, o_addr, o_wdata} !== {e_len, e_addr, e_wd}) begin
        bad++; $display("FAIL rnd_mux cyc=%0d got len=%h addr=%h wd=%h exp len=%h addr=%h wd=%h",
                        cyc, o_len, o_addr, o_wdata, e_len, e_addr, e_wd);
      end
      total++;
      if ({ackv, errv, m1_rdata, m0_rdata} !== {e_ack, e_ack & {2{dn_err}},
          e_ack[1] ? dn_rdata : 32'h0, e_ack[0] ? dn_rdata : 32'h0}) begin
        bad++; $display("FAIL rnd_resp cyc=%0d got ack=%b err=%b exp ack=%b err=%b",
                        cyc, ackv, errv, e_ack, e_ack & {2{dn_err}});
      end
      if (e_ack != 2'b00) begin
        if (qleft[0] == 1) begin
          void'(qid.pop_front());
          void'(qleft.pop_front());
        end else begin
          qleft[0] = qleft[0] - 1;
        end
      end
      if (g >= 0 && dn_accept) begin
        if (lock_m < 0) begin
          qid.push_back(g);
          qleft.push_back(rd[g] ? int'(len[g]) + 1 : 1);
          last = g;
          if (wr[g] != 4'h0 && len[g] != 8'h0) begin
            lock_m    = g;
            lock_left = int'(len[g]);
          end
        end else begin
          lock_left--;
          if (lock_left == 0) lock_m = -1;
        end
        if (isrd[g] || sent[g] == blen[g]) busy[g] = 1'b0;
        else sent[g]++;
      end
    end
    total++;
    if (!drained) begin
      bad++; $display("FAIL rnd_drain got pending=%0d exp 0", qid.size());
    end
    @(negedge clk); idle();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_round_robin();
    test_wr_burst();
    test_read_burst();
    test_fifo_full();
    test_error();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pmem_outport_arb.md
Name: pmem_outport_arb

Overview:
- 2:1 arbiter sharing one pmem outport (rd/wr/len/addr/data, accept/ack/error handshake) between master 0 (dcache_if path) and master 1 (icache path).
- Round-robin grant, write-burst locking, and up to OUTSTANDING in-flight requests.
- Response routing by an in-order tracking FIFO of {master id, expected ack count}.
- Sits between the cache-side bridges and the AXI4 outport converter.

Parameters:
- OUTSTANDING, 4, depth of response-tracking FIFO (max in-flight requests)
- ADDR_W, 2, log2(OUTSTANDING)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- m0_rd_i / m1_rd_i  in  1  read request, held until accept
- m0_wr_i / m1_wr_i  in  4  byte-enable write request, held until accept
- m0_len_i / m1_len_i  in  8  burst length minus one
- m0_addr_i / m1_addr_i  in  32  word address
- m0_write_data_i / m1_write_data_i  in  32  write beat data
- m0_accept_o / m1_accept_o  out  1  request beat accepted
- m0_ack_o / m1_ack_o  out  1  response beat
- m0_error_o / m1_error_o  out  1  response error, valid with ack
- m0_read_data_o / m1_read_data_o  out  32  read data, valid with ack
- outport_rd_o  out  1  granted read
- outport_wr_o  out  4  granted write strobes
- outport_len_o  out  8  granted length
- outport_addr_o  out  32  granted address
- outport_write_data_o  out  32  granted write data
- outport_accept_i  in  1  downstream accepted beat
- outport_ack_i  in  1  downstream response beat
- outport_error_i  in  1  downstream error
- outport_read_data_i  in  32  downstream read data

Behaviour:
Request and reset
- mN request = mN_rd_i | (mN_wr_i != 0).
- rd and wr are never asserted together by a master.
- Reset: all outputs 0; FIFO empty; lock clear; last_grant = 1, so m0 wins the first tie.

Arbitration
- Combinational, same cycle, when unlocked and FIFO not full.
- Single requester wins.
- Both requesting: the master other than last_grant wins.
- last_grant updates on each accepted first beat.
- FIFO full: no grant; outport_rd_o = 0, outport_wr_o = 0.
- Outport signals mux from the granted master; all zero if no grant.
- mN_accept_o = granted(N) & outport_accept_i.

Lock (states IDLE, WR_BURST)
- IDLE -> WR_BURST on an accepted write beat with len != 0.
- On entry, beat counter = len and the grant is frozen to that master.
- In WR_BURST:
  - No FIFO-full gating.
  - Only the locked master is muxed.
  - Each accepted beat decrements the counter.
  - Exit to IDLE when an accepted beat finds counter == 1.
- len = 0 write stays in IDLE.

Tracking FIFO
- Push on the first accepted beat of each request, whether read or write.
- Entry = {master id, expected acks}, where expected = len+1 for reads and 1 for writes.
- No push on write continuation beats.
- Full check uses the registered count only; no same-cycle pop bypass.

Response routing
- Head entry selects the master.
- mN_ack_o = outport_ack_i & fifo_valid & head==N.
- mN_read_data_o and mN_error_o are passed through, gated with that ack.
- resp_cnt counts acks.
- Pop and clear resp_cnt when ack arrives with resp_cnt == expected-1.
- outport_ack_i while FIFO empty is dropped; no master ack.
- Downstream ack latency is at least 1 cycle after accept.
- Push and pop in the same cycle leaves count unchanged.

Arithmetic
- 8-bit counters; len = 255 yields 256 beats or acks.
- Pointers wrap modulo OUTSTANDING.

Reset mid-operation
- Lock, FIFO, and counters clear.
- Acks still in flight after reset are dropped.

Decomposition:
- Shared package pmem_arb_pkg: master id constants (ARB_M0 = 0, ARB_M1 = 1), LEN_W = 8, DATA_W = 32, STRB_W = 4, FIFO entry width (1+9).
- One sub-module: pmem_arb_fifo, a generic push/pop/valid/accept FIFO with WIDTH/DEPTH/ADDR_W parameters, instantiated once for response tracking.

Test Plan:
1. Post-reset, m0 and m1 both issue single reads (len 0), accept always 1 -> m0 granted cycle 0, m1 cycle 1. Acks 2 and 4 cycles later route to m0 then m1 with data 0xA5A5_0000 / 0x5A5A_0001.
2. m1 write burst len=3 at 0x1000, m0 read pending -> four m1 beats contiguous, m0 held off (m0_accept_o = 0) until the 4th beat. Then m0 granted; one ack to m1.
3. m0 read len=7, ack on every cycle -> exactly 8 m0_ack_o pulses. FIFO pops on the 8th; m1 sees no ack.
4. Hold ack low, issue 4 single reads -> 5th request not granted (outport_rd_o = 0) until the first ack. Granted the cycle after that ack pops.
5. Error on the 2nd ack of an m1 read len=1 -> m1_error_o = 1 with that ack only; FIFO pops normally.
6. Assert rst mid write burst (beat 2 of 4) -> next cycle all outputs 0, lock clear. A stray outport_ack_i produces no mN_ack_o.
